edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel edge capture and scheduling block. Each of NCH level inputs gets its own edge detector, qualified by a per-channel mode. Detected edges are timestamped and held in a one-deep pending slot per channel. A round-robin arbiter drains the slots onto a single valid/ready event stream for the downstream consumer, and a sticky overflow flag records edges lost per channel.

## Interface
- NCH, 4: number of input channels (2..16).
- TS_W, 16: timestamp counter width.
- CH_W, $clog2(NCH): channel index width (derived).

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- signal_in  in  NCH  raw levels, already synchronous to clk.
- mode  in  2*NCH  per-channel mode, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts; a transfer occurs when evt_valid && evt_ready at a clk edge.
- evt_ch  out  CH_W  channel index of the event.
- evt_rise  out  1  1 = rising edge, 0 = falling edge.
- evt_ts  out  TS_W  timestamp of the edge.
- overflow  out  NCH  sticky per-channel lost-edge flag.
- ovf_clr  in  1  clears all overflow bits.

## Operation
- Reset values: prev[i]=0, pend=0, the output register empty, evt_valid=0, evt_ch/evt_rise/evt_ts=0, overflow=0, ts counter=0, rr pointer=NCH-1.
- Because prev resets to 0, a high signal_in at reset release yields a rising edge in the first cycle.
- Timestamp counter: increments every cycle and wraps from 2^TS_W-1 to 0.
- Edge detect per channel:
  - rise = signal_in & ~prev.
  - fall = ~signal_in & prev.
  - prev <= signal_in every cycle, regardless of mode.
- Qualification: an edge is kept only if the current-cycle mode enables it. Mode 00 drops all edges.
- Mode changes do not clear existing pending slots.
- Pending slot per channel holds pend, pend_rise and pend_ts.
- pend_ts is the counter value in the detect cycle, i.e. the value before the increment.
- Slot load rules for a qualified edge:
  - Slot empty: load it.
  - Slot full and being drained into the output register this cycle: load the new edge (drain and load coexist).
  - Slot full and not being drained: drop the new edge and set overflow[i]; the old slot content is kept.
- Overflow clear: ovf_clr clears all overflow bits. If ovf_clr and a new overflow occur in the same cycle, the new overflow bit is set (set wins).
- Output register (one entry) is free when evt_valid=0, or when evt_valid && evt_ready this cycle.
- Arbitration, when the output register is free and any pend=1:
  - Grant the first pending channel in order ptr+1, ptr+2, … (mod NCH).
  - Load ch/rise/ts into the output register and clear that slot.
  - Set ptr to the granted channel.
  - evt_valid is 1 next cycle.
- If the output register is free and nothing is pending, evt_valid goes to 0.
- Stability: while evt_valid && !evt_ready, evt_ch, evt_rise and evt_ts hold stable.
- Rising edge and falling edge are mutually exclusive per channel per cycle.
- Reset mid-operation (async): all state returns to reset values immediately, including an in-flight evt_valid; pending events are discarded.

## Timing
- Edge sampled at posedge t (signal_in != prev): pend set after t; evt_valid=1 after t+1 if the output register is free. Minimum latency is 2 edges from the first sample of the new level.
- Throughput: one event per cycle with evt_ready held at 1.
- After a transfer at edge k, the next event (if pending) is valid after edge k, i.e. with no bubble.
- overflow updates at the same edge as the dropped edge's detection.
- ptr updates only on grant.

## Test plan
- Reset: rst=1 with signal_in=0 → evt_valid=0, overflow=0. Release with signal_in=4'b0000 and mode=all 11 → no events for 20 cycles.
- Single edge: mode[1:0]=01, ch0 rises at edge where counter=37 → next cycle evt_valid=1, evt_ch=0, evt_rise=1, evt_ts=37. With evt_ready=1, evt_valid=0 one cycle later.
- Simultaneous: all modes 01, ch0..ch3 rise the same cycle, evt_ready=1 → four consecutive events with evt_ch 0,1,2,3, identical evt_ts. Then ch3 and ch0 rise together → ch0 granted first only if ptr=3 (it is), then ch3.
- Backpressure/overflow: evt_ready=0, mode ch1=11, ch1 rise/fall/rise on 3 consecutive cycles → output holds rise, slot holds fall, overflow[1]=1. Raise evt_ready → events rise then fall, then evt_valid=0. Pulse ovf_clr → overflow=0.
- Mode filter: ch2 mode=10, 1-cycle high pulse → only one event (evt_rise=0). Repeat with mode=00 → no event, no overflow.
- Async reset mid-stream: assert rst while evt_valid=1 and pend≠0, between clock edges → evt_valid=0 and overflow=0 immediately. After release, the counter restarts at 0 and no stale events appear.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Captures rising/falling edges on NCH synchronous level inputs, tags each
//   edge with a free-running timestamp and holds it in a one-deep slot per
//   channel. A round-robin arbiter moves slots into a single output register
//   that feeds a valid/ready event stream. Edges that arrive while their slot
//   is still occupied are dropped and flagged in a sticky overflow bit.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   signal_in  [NCH]     raw levels, synchronous to clk
//   mode       [2*NCH]   per channel: 00 off, 01 rising, 10 falling, 11 both
//   evt_valid  event available
//   evt_ready  consumer accepts (transfer on evt_valid && evt_ready)
//   evt_ch     [CH_W]    channel of the presented event
//   evt_rise   1 = rising edge, 0 = falling edge
//   evt_ts     [TS_W]    timestamp of the edge
//   overflow   [NCH]     sticky lost-edge flags
//   ovf_clr    clear all overflow flags (a same-cycle new loss still sets)
module edge_event_arbiter #(
  parameter int NCH  = 4,
  parameter int TS_W = 16,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    signal_in,
  input  logic [2*NCH-1:0]  mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rise,
  output logic [TS_W-1:0]   evt_ts,
  output logic [NCH-1:0]    overflow,
  input  logic              ovf_clr
);

  logic [NCH-1:0]  prev;
  logic [TS_W-1:0] ts_count;
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  pend_rise;
  logic [TS_W-1:0] pend_ts [NCH];
  logic [CH_W-1:0] ptr;

  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  fall;
  logic [NCH-1:0]  qual;
  logic [NCH-1:0]  drain;
  logic [NCH-1:0]  load;
  logic [NCH-1:0]  lost;

  logic            out_free;
  logic            load_out;
  logic            grant_valid;
  logic [CH_W-1:0] grant_idx;

  // The output register can take a new entry when empty or when its current
  // entry is leaving this very cycle, which gives back-to-back events.
  assign out_free = !evt_valid || evt_ready;
  assign load_out = out_free && grant_valid;

  // Round-robin search starting just after the last granted channel. Only
  // slots that were already full at the start of the cycle take part, so a
  // freshly detected edge is never granted in its own detect cycle.
  always_comb begin
    int              s;
    logic [CH_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      s = int'(ptr) + k;
      if (s >= NCH) s = s - NCH;
      cand = CH_W'(s);
      if (!grant_valid && pend[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign rise[gi]  = signal_in[gi] & ~prev[gi];
      assign fall[gi]  = ~signal_in[gi] & prev[gi];
      assign qual[gi]  = (rise[gi] & mode[2*gi]) | (fall[gi] & mode[2*gi+1]);
      assign drain[gi] = load_out && (grant_idx == CH_W'(gi));
      // A slot emptied into the output register this cycle may be refilled
      // in the same cycle; otherwise a full slot keeps its older edge.
      assign load[gi]  = qual[gi] && (!pend[gi] || drain[gi]);
      assign lost[gi]  = qual[gi] && pend[gi] && !drain[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      ts_count  <= '0;
      pend      <= '0;
      pend_rise <= '0;
      for (int i = 0; i < NCH; i++) pend_ts[i] <= '0;
      ptr       <= CH_W'(NCH - 1);
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      evt_ts    <= '0;
      overflow  <= '0;
    end else begin
      prev     <= signal_in;
      ts_count <= ts_count + 1'b1;

      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          pend[i]      <= 1'b1;
          pend_rise[i] <= rise[i];
          pend_ts[i]   <= ts_count;
        end else if (drain[i]) begin
          pend[i] <= 1'b0;
        end
      end

      // Clear first, then OR in new losses so a same-cycle loss survives.
      overflow <= (ovf_clr ? '0 : overflow) | lost;

      if (load_out) begin
        evt_valid <= 1'b1;
        evt_ch    <= grant_idx;
        evt_rise  <= pend_rise[grant_idx];
        evt_ts    <= pend_ts[grant_idx];
        ptr       <= grant_idx;
      end else if (out_free) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: directed stimulus pushes expected events
// into a queue; a negedge monitor pops and compares on every transfer.
module tb_edge_event_arbiter;

  localparam int NCH  = 4;
  localparam int TS_W = 16;
  localparam int CH_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    signal_in;
  logic [2*NCH-1:0]  mode;
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_ch;
  logic              evt_rise;
  logic [TS_W-1:0]   evt_ts;
  logic [NCH-1:0]    overflow;
  logic              ovf_clr;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            rise;
    logic [TS_W-1:0] ts;
  } evt_t;

  evt_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc;   // reference count of edges since reset release

  edge_event_arbiter #(.NCH(NCH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .signal_in (signal_in),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .evt_ts    (evt_ts),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push_exp(input int ch, input logic r, input int ts);
    evt_t e;
    e.ch   = CH_W'(ch);
    e.rise = r;
    e.ts   = TS_W'(ts);
    exp_q.push_back(e);
  endtask

  // Monitor: one line per transfer, plus hold-stability under backpressure.
  initial begin
    evt_t e;
    evt_t got;
    evt_t held;
    bit   held_vld;
    held_vld = 0;
    forever begin
      @(negedge clk);
      if (rst || !evt_valid) begin
        held_vld = 0;
      end else begin
        got.ch   = evt_ch;
        got.rise = evt_rise;
        got.ts   = evt_ts;
        if (evt_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected: got ch=%0d rise=%0d ts=%0d, none required",
                     got.ch, got.rise, got.ts);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL event: got ch=%0d rise=%0d ts=%0d required ch=%0d rise=%0d ts=%0d",
                       got.ch, got.rise, got.ts, e.ch, e.rise, e.ts);
            end else begin
              $display("ok   event: ch=%0d rise=%0d ts=%0d", got.ch, got.rise, got.ts);
            end
          end
          held_vld = 0;
        end else begin
          if (held_vld) begin
            total++;
            if (got !== held) begin
              bad++;
              $display("FAIL hold_stable: got ch=%0d rise=%0d ts=%0d required ch=%0d rise=%0d ts=%0d",
                       got.ch, got.rise, got.ts, held.ch, held.rise, held.ts);
            end
          end
          held     = got;
          held_vld = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int c;
    rst       = 1'b1;
    signal_in = '0;
    mode      = 8'hFF;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset state and idle with all edges enabled.
    tick(3);
    check("reset_valid", 32'(evt_valid), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst       = 1'b0;
    evt_ready = 1'b1;
    tick(20);
    check("idle_valid", 32'(evt_valid), 32'd0);

    // Single rising edge on ch0 detected at counter value 37.
    mode  = 8'h01;
    guard = 0;
    while (cyc != 37 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_cnt37", 32'(cyc), 32'd37);
    signal_in[0] = 1'b1;
    push_exp(0, 1'b1, 37);
    tick();
    check("single_latency", 32'(evt_valid), 32'd0);
    tick();
    check("single_valid", 32'(evt_valid), 32'd1);
    signal_in[0] = 1'b0;
    tick();
    check("single_done", 32'(evt_valid), 32'd0);

    // Fresh reset so the round-robin pointer starts at NCH-1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);

    // All four rise together: grant order 0,1,2,3 with one timestamp.
    mode      = 8'h55;
    c         = cyc;
    signal_in = 4'hF;
    for (int i = 0; i < 4; i++) push_exp(i, 1'b1, c);
    tick();
    signal_in = 4'h0;
    tick(6);
    // Pointer now 3: ch0 wins over ch3.
    c         = cyc;
    signal_in = 4'h9;
    push_exp(0, 1'b1, c);
    push_exp(3, 1'b1, c);
    tick();
    signal_in = 4'h0;
    tick(4);
    check("sim_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: rise/fall/rise on ch1 while the consumer stalls.
    evt_ready = 1'b0;
    mode      = 8'h0C;
    c         = cyc;
    signal_in[1] = 1'b1;
    tick();
    signal_in[1] = 1'b0;
    tick();
    signal_in[1] = 1'b1;
    tick();
    check("bp_overflow", 32'(overflow), 32'h2);
    check("bp_valid", 32'(evt_valid), 32'd1);
    check("bp_out_rise", 32'(evt_rise), 32'd1);
    push_exp(1, 1'b1, c);
    push_exp(1, 1'b0, c + 1);
    tick(3);
    evt_ready = 1'b1;
    tick(3);
    check("bp_empty", 32'(evt_valid), 32'd0);
    check("bp_ovf_sticky", 32'(overflow), 32'h2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);
    mode      = 8'h00;
    signal_in = 4'h0;
    tick(2);

    // Mode filter: ch2 falling only; one-cycle pulse yields a single fall.
    mode = 8'h20;
    c    = cyc;
    signal_in[2] = 1'b1;
    tick();
    signal_in[2] = 1'b0;
    push_exp(2, 1'b0, c + 1);
    tick(4);
    check("filter_drained", 32'(exp_q.size()), 32'd0);
    mode = 8'h00;
    signal_in[2] = 1'b1;
    tick();
    signal_in[2] = 1'b0;
    tick(4);
    check("disabled_valid", 32'(evt_valid), 32'd0);
    check("disabled_ovf", 32'(overflow), 32'h0);

    // Async reset while an event is held and slots are still pending.
    evt_ready = 1'b0;
    mode      = 8'h55;
    signal_in = 4'hF;
    tick(2);
    check("pre_reset_valid", 32'(evt_valid), 32'd1);
    #2;
    rst       = 1'b1;
    #1;
    check("async_valid", 32'(evt_valid), 32'd0);
    check("async_ovf", 32'(overflow), 32'h0);
    signal_in = 4'h0;
    evt_ready = 1'b1;
    tick(2);
    // Released with ch0 high: rising edge at the first counter value, 0.
    rst       = 1'b0;
    signal_in = 4'h1;
    push_exp(0, 1'b1, 0);
    tick(4);
    signal_in = 4'h0;
    tick(10);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    check("final_valid", 32'(evt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
